// File: rtl/ddsm_pkg.sv
// rtl/ddsm_pkg.sv - shared constants, result type and operand helper for the MASH noise-cancellation network
package ddsm_pkg;

    localparam int NCN_MIN_W    = 4;
    localparam int NCN_LAT_BASE = 1;

    typedef logic signed [NCN_MIN_W-1:0] ncn_y_t;

    // Widen a single carry bit into a 4-bit operand (the value is always 0 or +1).
    function automatic logic [3:0] ncn_ext1(input logic b);
        return {3'b000, b};
    endfunction

endpackage

// File: rtl/sub_lca_4bit.sv
// rtl/sub_lca_4bit.sv - combinational 4-bit lookahead-borrow subtractor (a - b - bin)
module sub_lca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic [3:0] borrow
);

    logic [3:0] g;
    logic [3:0] p;

    // Borrow generate when a=0,b=1; borrow propagates through bits where a equals b.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow[i] is the borrow out of bit i, flattened so no ripple chain.
    assign borrow[0] = g[0] | (p[0] & bin);
    assign borrow[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign borrow[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & bin);
    assign borrow[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign diff = a ^ b ^ {borrow[2:0], bin};

endmodule

// File: rtl/mash_ncn_111.sv
// rtl/mash_ncn_111.sv - MASH 1-1-1 noise-cancellation sum; NCN_PIPE_EN adds a register after the difference stage
module mash_ncn_111
    import ddsm_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_c1,
    input  logic             i_c2,
    input  logic             i_c3,
    output logic [OUT_W-1:0] o_y,
    output logic             o_valid
);

    logic       c2_z1;
    logic       c3_z1;
    logic       c3_z2;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d3_a;
    logic [3:0] d3_b;
    logic [3:0] d2_borrow_unused;
    logic [3:0] d3_borrow_unused;
    logic       sum_c1;
    logic [3:0] sum_d2;
    logic [3:0] sum_d3;
    logic       sum_valid;
    ncn_y_t     sum4;
    logic [OUT_W-1:0] y_ext;

    // c2[n] - c2[n-1]
    sub_lca_4bit u_sub_c2 (
        .a      (ncn_ext1(i_c2)),
        .b      (ncn_ext1(c2_z1)),
        .bin    (1'b0),
        .diff   (d2),
        .borrow (d2_borrow_unused)
    );

    // (c3[n] + c3[n-2]) - 2*c3[n-1]; the doubling is a one-bit left shift
    assign d3_a = ncn_ext1(i_c3) + ncn_ext1(c3_z2);
    assign d3_b = {2'b00, c3_z1, 1'b0};

    sub_lca_4bit u_sub_c3 (
        .a      (d3_a),
        .b      (d3_b),
        .bin    (1'b0),
        .diff   (d3),
        .borrow (d3_borrow_unused)
    );

`ifdef NCN_PIPE_EN
    logic       s_valid;
    logic       s_c1;
    logic [3:0] s_d2;
    logic [3:0] s_d3;

    // Difference-stage register; cleared with the rest of the state so no stale sample survives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_valid <= 1'b0;
            s_c1    <= 1'b0;
            s_d2    <= 4'd0;
            s_d3    <= 4'd0;
        end else if (i_clr) begin
            s_valid <= 1'b0;
            s_c1    <= 1'b0;
            s_d2    <= 4'd0;
            s_d3    <= 4'd0;
        end else begin
            s_valid <= i_en;
            if (i_en) begin
                s_c1 <= i_c1;
                s_d2 <= d2;
                s_d3 <= d3;
            end
        end
    end

    assign sum_valid = s_valid;
    assign sum_c1    = s_c1;
    assign sum_d2    = s_d2;
    assign sum_d3    = s_d3;
`else
    assign sum_valid = i_en;
    assign sum_c1    = i_c1;
    assign sum_d2    = d2;
    assign sum_d3    = d3;
`endif

    // Range is -3..+4, so the 4-bit wrap-around sum is exact; signed cast sign-extends to OUT_W.
    assign sum4  = ncn_y_t'(ncn_ext1(sum_c1) + sum_d2 + sum_d3);
    assign y_ext = OUT_W'(sum4);

    // Carry history advances only on accepted samples; output register holds between samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c2_z1   <= 1'b0;
            c3_z1   <= 1'b0;
            c3_z2   <= 1'b0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end else if (i_clr) begin
            c2_z1   <= 1'b0;
            c3_z1   <= 1'b0;
            c3_z2   <= 1'b0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end else begin
            if (i_en) begin
                c2_z1 <= i_c2;
                c3_z1 <= i_c3;
                c3_z2 <= c3_z1;
            end
            o_valid <= sum_valid;
            if (sum_valid) begin
                o_y <= y_ext;
            end
        end
    end

endmodule

// File: tb/tb_mash_ncn_111.sv
// tb/tb_mash_ncn_111.sv - scoreboard bench for mash_ncn_111 (default build and NCN_PIPE_EN)
module tb_mash_ncn_111;

    localparam int OUT_W = 6;
`ifdef NCN_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b1;
    logic             i_en = 1'b0;
    logic             i_clr = 1'b0;
    logic             i_c1 = 1'b0;
    logic             i_c2 = 1'b0;
    logic             i_c3 = 1'b0;
    logic [OUT_W-1:0] o_y;
    logic             o_valid;

    int errors = 0;
    int checks = 0;

    logic signed [OUT_W-1:0] exp_q[$];
    logic signed [OUT_W-1:0] held = '0;
    logic m_c2 = 1'b0;
    logic m_c3a = 1'b0;
    logic m_c3b = 1'b0;

    mash_ncn_111 #(.OUT_W(OUT_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_c1    (i_c1),
        .i_c2    (i_c2),
        .i_c3    (i_c3),
        .o_y     (o_y),
        .o_valid (o_valid)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each valid output pops one expected value; idle cycles must hold the last value.
    always @(negedge i_clk) begin
        logic signed [OUT_W-1:0] e;
        checks++;
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: o_y=%0d, required no output", $signed(o_y));
            end else begin
                e = exp_q.pop_front();
                if ($signed(o_y) !== e) begin
                    errors++;
                    $display("FAIL sample_value: o_y=%0d (%b), required %0d (%b)", $signed(o_y), o_y, e, e);
                end
                held = e;
            end
        end else if (o_valid !== 1'b0 || $signed(o_y) !== held) begin
            errors++;
            $display("FAIL idle_hold: o_valid=%b o_y=%0d, required o_valid=0 o_y=%0d", o_valid, $signed(o_y), held);
        end
    end

    task automatic step(input logic en, input logic clr, input logic c1, input logic c2, input logic c3);
        int y;
        @(negedge i_clk);
        #1;
        i_en = en; i_clr = clr; i_c1 = c1; i_c2 = c2; i_c3 = c3;
        if (clr) begin
            exp_q.delete();
            held = '0;
            m_c2 = 1'b0; m_c3a = 1'b0; m_c3b = 1'b0;
        end else if (en) begin
            y = int'(c1) + int'(c2) - int'(m_c2) + int'(c3) - 2 * int'(m_c3a) + int'(m_c3b);
            exp_q.push_back(OUT_W'(y));
            m_c2 = c2;
            m_c3b = m_c3a;
            m_c3a = c3;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        #2 i_rst_n = 1'b0;
        #2;
        checks++;
        if (o_y !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: o_y=%b o_valid=%b, required 0 and 0", o_y, o_valid);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic test_zero_latency;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        checks++;
        if (o_valid !== (LAT == 1)) begin
            errors++;
            $display("FAIL first_latency: o_valid=%b one edge after sample, required %b", o_valid, LAT == 1);
        end
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_c1_const;
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_c3_impulse;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_extremes;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checks++;
        if ($signed(o_y) !== -3) begin
            errors++;
            $display("FAIL min_extreme: o_y=%0d, required -3", $signed(o_y));
        end
    endtask

    task automatic test_gaps;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        repeat (3) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(3);
        end
    endtask

    task automatic test_back_to_back;
        repeat (40) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        idle(3);
    endtask

    task automatic test_reset_mid;
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge i_clk);
        #1 i_en = 1'b0;
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_y !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: o_y=%b o_valid=%b, required 0 and 0", o_y, o_valid);
        end
        exp_q.delete();
        held = '0;
        m_c2 = 1'b0; m_c3a = 1'b0; m_c3b = 1'b0;
        #1 i_rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic test_clr_priority;
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge i_clk);
        #1;
        checks++;
        if (o_y !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: o_y=%b o_valid=%b, required 0 and 0", o_y, o_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_c1_const();
        test_c3_impulse();
        test_extremes();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_clr_priority();
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mash_ncn_111.md
MASH_NCN_111 -- requirements
Module: mash_ncn_111

Interface
REQ-001 Parameter OUT_W, default 4, signed output width; SHALL be >= 4.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_en  input  1  sample strobe; carries valid in the cycle it is high.
REQ-005 i_clr  input  1  synchronous clear of history and output.
REQ-006 i_c1  input  1  stage-1 accumulator carry.
REQ-007 i_c2  input  1  stage-2 accumulator carry.
REQ-008 i_c3  input  1  stage-3 accumulator carry.
REQ-009 o_y  output  OUT_W  two's-complement modulator output.
REQ-010 o_valid  output  1  o_y updated this cycle.

Function
REQ-011 The block SHALL compute y[n] = c1[n] + (c2[n] - c2[n-1]) + (c3[n] - 2*c3[n-1] + c3[n-2]), where n counts i_en samples, not clocks.
REQ-012 History registers c2_z1, c3_z1 and c3_z2 SHALL advance only on cycles with i_en=1.
REQ-013 Result range SHALL be -3..+4, exact with no saturation; for OUT_W > 4 it SHALL be sign-extended.
REQ-014 Latency SHALL be 1 clock: o_y and o_valid register on the edge that samples i_en=1.
REQ-015 o_valid SHALL be 1 for exactly one cycle per i_en sample and 0 otherwise.
REQ-016 With i_en=0, o_y SHALL hold its last value and history SHALL hold.
REQ-017 i_clr=1 SHALL zero history, o_y and o_valid on the next edge.
REQ-018 i_clr SHALL take priority over a simultaneous i_en; that sample is discarded.
REQ-019 Back-to-back i_en every cycle SHALL be sustained, with one result per cycle.
REQ-020 Differences SHALL be formed by sub_lca_4bit instances on sign-extended 4-bit operands; 2*c3[n-1] is a left shift.

Reset
REQ-021 i_rst_n=0 SHALL immediately force o_y=0, o_valid=0 and all history to 0, regardless of clock.
REQ-022 Reset asserted mid-stream SHALL discard in-flight data; the first sample after release SHALL see zero history.
REQ-023 Deassertion SHALL be synchronized externally; the block samples inputs from the first edge after release.

Configuration
REQ-024 Macro NCN_PIPE_EN defined: add a register between the difference stage and the final sum; latency becomes 2; o_valid is delayed to match; i_clr and reset also clear this stage.
REQ-025 NCN_PIPE_EN undefined: latency is 1 per REQ-014; there is no extra register.

Structure
REQ-026 Shared package ddsm_pkg SHALL hold NCN_MIN_W=4, NCN_LAT_BASE=1 and the signed result typedef ncn_y_t.
REQ-027 Sub-module sub_lca_4bit SHALL provide a combinational 4-bit lookahead-borrow subtractor (a - b - bin), returning the difference and per-bit borrow, as the inverse of the team's lookahead adder.
REQ-028 The target RTL size is 120-400 lines in total, including the sub-module.

Verification
REQ-029 Reset, then i_en=1 with all carries 0 for 8 cycles -> o_y=0 and o_valid=1 from cycle 1.
REQ-030 c1=1, c2=c3=0 continuously -> o_y=1 every valid cycle.
REQ-031 c3 impulse sequence 1,0,0,0 with others 0 -> o_y sequence +1, -2, +1, 0 (4-bit: 0001, 1110, 0001, 0000).
REQ-032 Extremes: c2 sequence 0,1 and c3 sequence 1,0,1 with c1=1 -> final o_y=+4 (0100); c2 sequence 1,0 and c3 sequence 0,1,0 with c1=0 -> o_y=-3 (1101).
REQ-033 i_en gaps of 3 idle cycles inserted into the REQ-031 sequence -> identical o_y values, o_y held and o_valid=0 in the gaps.
REQ-034 i_rst_n pulsed low between clock edges mid-stream -> o_y=0 and o_valid=0 immediately; next sample uses zero history. i_clr and i_en high together -> output 0 and the sample is dropped.
REQ-035 All scenarios SHALL be rerun with NCN_PIPE_EN defined; the expected values are unchanged and latency is 2.
